// File: rtl/usb_tx_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_timer_ctrl_if
// Description : Handshake bundle between the USB TX bit timer and the upstream
//               byte source / byte shift register.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_timer_ctrl_if;
    logic       sending;
    logic       byte_valid;
    logic       stop_clock;
    logic       load_enable;
    logic       shift_enable;
    logic       byte_ack;
    logic       busy;
    logic       tx_done;
    logic       underrun;
    logic [2:0] bit_cnt;

    modport master (
        output sending, byte_valid, stop_clock,
        input  load_enable, shift_enable, byte_ack, busy, tx_done, underrun, bit_cnt
    );

    modport slave (
        input  sending, byte_valid, stop_clock,
        output load_enable, shift_enable, byte_ack, busy, tx_done, underrun, bit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_timer_ctrl
// Description : Bit-period timer that paces load/shift of the USB TX byte
//               shift register, with bit-stuff stall and underrun detection.
//               Optional abort input enabled by macro USB_TX_TIMER_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_timer_ctrl #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef USB_TX_TIMER_ABORT_EN
    input  logic                abort,
`endif
    usb_tx_timer_ctrl_if.slave  bus
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_cnt;
    logic               r_underrun;

    logic w_abort;
    logic w_boundary;
    logic w_next_byte;
    logic w_load;
    logic w_shift;

`ifdef USB_TX_TIMER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // A stuffed bit (stop_clock at a boundary) suppresses both load and shift.
    always_comb begin
        w_boundary  = (r_state == S_RUN) && (r_clk_cnt == c_LAST);
        w_next_byte = bus.sending && bus.byte_valid;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        if (r_state == S_IDLE) begin
            w_load = w_next_byte;
        end else if (w_boundary && !bus.stop_clock && !w_abort) begin
            if (r_bit_cnt != 3'd7) begin
                w_shift = 1'b1;
            end else begin
                w_load = w_next_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= 3'd0;
            r_underrun <= 1'b0;
        end else if (w_abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next_byte) begin
                        r_state    <= S_RUN;
                        r_clk_cnt  <= '0;
                        r_bit_cnt  <= 3'd0;
                        r_underrun <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_clk_cnt <= w_boundary ? '0 : r_clk_cnt + 1'b1;
                    if (w_boundary && !bus.stop_clock) begin
                        if (r_bit_cnt != 3'd7) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (w_next_byte) begin
                            r_bit_cnt <= 3'd0;
                        end else begin
                            // Upstream still claims a packet but has no byte: starved.
                            r_state   <= S_DONE;
                            r_bit_cnt <= 3'd0;
                            if (bus.sending) begin
                                r_underrun <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_enable  = w_load;
    assign bus.byte_ack     = w_load;
    assign bus.shift_enable = w_shift;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.tx_done      = (r_state == S_DONE);
    assign bus.underrun     = r_underrun;
    assign bus.bit_cnt      = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_timer_ctrl
// Description : Directed table-driven bench for usb_tx_timer_ctrl
//               (CLKS_PER_BIT = 8); cycle offsets are relative to the accept.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_timer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef USB_TX_TIMER_ABORT_EN
    logic abort = 1'b0;
`endif

    usb_tx_timer_ctrl_if bus_if ();

    usb_tx_timer_ctrl #(
        .CLKS_PER_BIT (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef USB_TX_TIMER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string name;
        int    nbytes;
        int    hold;
        int    stuff_k;
        int    exp_nsh;
        int    exp_first;
        int    exp_last;
        int    exp_ack2;
        int    exp_done;
        int    exp_ur;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus_if.sending    = 1'b0;
        bus_if.byte_valid = 1'b0;
        bus_if.stop_clock = 1'b0;
    endtask

    // Accept in cycle t, then run 150 further cycles recording what happens.
    task automatic run_vec(input vec_t v);
        int done_k = -1, ack2_k = -1, first_k = -1, last_k = -1;
        int nsh = 0, ndone = 0, viol = 0;
        int ur_done = -1, busy_after = -1, ur_k1 = -1;
        @(posedge clk); #1;
        bus_if.sending    = 1'b1;
        bus_if.byte_valid = 1'b1;
        bus_if.stop_clock = 1'b0;
        @(negedge clk);
        chk({v.name, ".accept"}, int'(bus_if.load_enable && bus_if.byte_ack), 1);
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk); #1;
            bus_if.sending    = (v.hold != 0) || (v.nbytes == 2 && k <= 64);
            bus_if.byte_valid = (v.nbytes == 2 && k == 64);
            bus_if.stop_clock = (k == v.stuff_k);
            @(negedge clk);
            if (bus_if.shift_enable) begin
                nsh++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (bus_if.byte_ack && ack2_k < 0) ack2_k = k;
            if (bus_if.tx_done) begin
                ndone++;
                if (done_k < 0) begin
                    done_k  = k;
                    ur_done = int'(bus_if.underrun);
                end
            end
            if (done_k >= 0 && k == done_k + 1) busy_after = int'(bus_if.busy);
            if (k == 1) ur_k1 = int'(bus_if.underrun);
            if ((bus_if.shift_enable && bus_if.load_enable) ||
                (bus_if.byte_ack && !bus_if.byte_valid) ||
                (bus_if.byte_ack != bus_if.load_enable)) viol++;
        end
        drive_idle();
        chk({v.name, ".nshift"},     nsh,        v.exp_nsh);
        chk({v.name, ".first_sh"},   first_k,    v.exp_first);
        chk({v.name, ".last_sh"},    last_k,     v.exp_last);
        chk({v.name, ".ack2"},       ack2_k,     v.exp_ack2);
        chk({v.name, ".done_k"},     done_k,     v.exp_done);
        chk({v.name, ".ndone"},      ndone,      1);
        chk({v.name, ".ur_done"},    ur_done,    v.exp_ur);
        chk({v.name, ".ur_k1"},      ur_k1,      0);
        chk({v.name, ".busy_after"}, busy_after, 0);
        chk({v.name, ".violations"}, viol,       0);
    endtask

    initial begin
        vecs[0] = '{"single",  1, 0, 0,  7, 8,  56, -1,  65, 0};
        vecs[1] = '{"b2b",     2, 0, 0, 14, 8, 120, 64, 129, 0};
        vecs[2] = '{"stuff24", 1, 0, 24, 7, 8,  64, -1,  73, 0};
        vecs[3] = '{"starve",  1, 1, 0,  7, 8,  56, -1,  65, 1};
        vecs[4] = '{"after_ur",1, 0, 0,  7, 8,  56, -1,  65, 0};

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.busy",     int'(bus_if.busy),         0);
        chk("rst.tx_done",  int'(bus_if.tx_done),      0);
        chk("rst.underrun", int'(bus_if.underrun),     0);
        chk("rst.bit_cnt",  int'(bus_if.bit_cnt),      0);
        chk("rst.shift",    int'(bus_if.shift_enable), 0);
        chk("rst.load",     int'(bus_if.load_enable),  0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset mid-byte: bit 3 in progress at t+30, everything clears from t+31.
        begin
            int ndone = 0, nsh_after = 0;
            @(posedge clk); #1;
            bus_if.sending    = 1'b1;
            bus_if.byte_valid = 1'b1;
            for (int k = 1; k <= 80; k++) begin
                @(posedge clk); #1;
                bus_if.sending    = 1'b0;
                bus_if.byte_valid = 1'b0;
                rst               = (k == 30);
                @(negedge clk);
                if (k == 30) chk("mid_rst.bit_cnt_before", int'(bus_if.bit_cnt), 3);
                if (k == 31) begin
                    chk("mid_rst.busy",    int'(bus_if.busy),         0);
                    chk("mid_rst.shift",   int'(bus_if.shift_enable), 0);
                    chk("mid_rst.load",    int'(bus_if.load_enable),  0);
                    chk("mid_rst.bit_cnt", int'(bus_if.bit_cnt),      0);
                end
                if (bus_if.tx_done) ndone++;
                if (k > 30 && bus_if.shift_enable) nsh_after++;
            end
            rst = 1'b0;
            chk("mid_rst.ndone",     ndone,     0);
            chk("mid_rst.nsh_after", nsh_after, 0);
        end

`ifdef USB_TX_TIMER_ABORT_EN
        begin
            int ndone = 0, nsh_after = 0, busy21 = -1;
            @(posedge clk); #1;
            bus_if.sending    = 1'b1;
            bus_if.byte_valid = 1'b1;
            for (int k = 1; k <= 80; k++) begin
                @(posedge clk); #1;
                bus_if.sending    = 1'b0;
                bus_if.byte_valid = 1'b0;
                abort             = (k == 20);
                @(negedge clk);
                if (k == 21) busy21 = int'(bus_if.busy);
                if (bus_if.tx_done) ndone++;
                if (k > 20 && bus_if.shift_enable) nsh_after++;
            end
            abort = 1'b0;
            chk("abort.busy21",    busy21,    0);
            chk("abort.ndone",     ndone,     0);
            chk("abort.nsh_after", nsh_after, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_timer_ctrl.md
USB_TX_TIMER_CTRL -- requirements
Module: usb_tx_timer_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clocks per bit period; legal values are 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port sending  input  1  packet in progress; upstream holds it high until its last byte is acknowledged.
REQ-005 SHALL have port byte_valid  input  1  upstream byte available for the shifter.
REQ-006 SHALL have port stop_clock  input  1  bit-stuff request; sampled only at bit boundaries.
REQ-007 SHALL have port load_enable  output  1  parallel-load pulse to the byte shift register.
REQ-008 SHALL have port shift_enable  output  1  one-bit shift pulse to the byte shift register.
REQ-009 SHALL have port byte_ack  output  1  consumes the upstream byte; coincident with load_enable.
REQ-010 SHALL have ports busy  output  1, tx_done  output  1, underrun  output  1, and bit_cnt  output  3 (current bit index).

Function
REQ-011 SHALL implement states IDLE, RUN and DONE, with busy = (state != IDLE).
REQ-012 In IDLE, when sending && byte_valid, SHALL assert load_enable and byte_ack combinationally that cycle, then enter RUN with clk_cnt=0, bit_cnt=0 and underrun cleared.
REQ-013 In RUN, clk_cnt SHALL count 0..CLKS_PER_BIT-1 and wrap; the cycle where clk_cnt==CLKS_PER_BIT-1 is the bit boundary.
REQ-014 At a boundary with stop_clock=1: no shift_enable, no load_enable, bit_cnt holds (stuffed bit occupies one full period), clk_cnt wraps normally.
REQ-015 At a boundary with stop_clock=0 and bit_cnt<7: shift_enable=1 for that cycle and bit_cnt increments.
REQ-016 At a boundary with stop_clock=0, bit_cnt==7 and sending && byte_valid: load_enable=1 and byte_ack=1 that cycle (replacing the shift), bit_cnt->0, remain in RUN; there is no gap between bytes.
REQ-017 At a boundary with stop_clock=0, bit_cnt==7 and no next byte: go to DONE; if sending==1 (starved), set underrun.
REQ-018 DONE SHALL last exactly one cycle with tx_done=1, then go to IDLE.
REQ-019 underrun SHALL be sticky until rst or the next IDLE accept.
REQ-020 Deasserting sending mid-byte SHALL NOT truncate the byte; the current byte always completes.
REQ-021 byte_ack SHALL never assert while byte_valid=0, and shift_enable and load_enable SHALL never assert in the same cycle.
REQ-022 Outputs SHALL be combinational decodes of registered state, counters and current inputs only.

Reset
REQ-023 rst SHALL force state=IDLE, clk_cnt=0, bit_cnt=0 and underrun=0, giving all outputs 0 on the next cycle.
REQ-024 rst SHALL take priority over every other input, including mid-RUN and in DONE; tx_done SHALL NOT pulse due to reset.

Configuration
REQ-025 When macro USB_TX_TIMER_ABORT_EN is defined, SHALL add port abort  input  1.
REQ-026 With the macro defined, abort=1 in RUN or DONE SHALL force IDLE on the next edge, clear the counters, and generate no tx_done; abort SHALL be ignored in IDLE.
REQ-027 With the macro undefined, the abort port and its logic SHALL be absent and behaviour is per REQ-011..022.

Verification (CLKS_PER_BIT=8, accept at cycle t)
REQ-028 Single byte 0xBB, sending drops after ack -> load_enable@t, shift_enable@t+8,16,...,56 (7 pulses), tx_done@t+65, busy=0@t+66, underrun=0.
REQ-029 Two bytes back-to-back -> byte_ack@t and @t+64, no shift_enable@t+64, tx_done@t+129.
REQ-030 stop_clock=1 during cycle t+24 only -> no pulse @t+24, remaining shifts @t+32,...,64, tx_done@t+73.
REQ-031 sending held high, byte_valid=0 @t+64 -> underrun=1 from t+65, tx_done@t+65; next accept clears underrun.
REQ-032 rst=1 @t+30 mid-byte -> busy, shift_enable, load_enable and bit_cnt all 0 from t+31, no tx_done.
REQ-033 With USB_TX_TIMER_ABORT_EN, abort@t+20 -> IDLE @t+21, no further shifts, tx_done never asserted.
